// File: rtl/dma_axi_wr_responder.sv
// dma_axi_wr_responder
//   AXI write-channel slave for DMA bursts. Accepts one INCR burst at a time
//   (AW, then AWLEN+1 W beats), writes each beat into a single-port
//   word-addressed SRAM with one cycle of registered latency, then returns a
//   single B response.
//
//   Optional build macro: DMA_WR_RESP_ADDR_CHECK_EN
//     When defined, a burst whose byte range ends beyond ADDR_LIMIT has all of
//     its beats accepted and dropped, and it is answered with DECERR. When
//     undefined, the address wraps in MEM_AW word bits and ADDR_LIMIT is unused.
module dma_axi_wr_responder #(
  parameter int          ID_W       = 4,
  parameter int          MEM_AW     = 14,
  parameter logic [31:0] ADDR_LIMIT = 32'h0001_0000
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   AWID,
  input  logic [31:0]       AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  output logic              mem_cs,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [1:0]        state;
  logic [MEM_AW-1:0] ptr;      // word address of the next beat
  logic [3:0]        cnt;      // beats remaining after the current one
  logic              err;      // WLAST placement disagreed with AWLEN
  logic              dec;      // burst rejected by the range check

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic last_beat;
  logic beat_err;
  logic aw_dec;
  logic beat_write;

  assign aw_hs      = AWVALID & AWREADY;
  assign w_hs       = WVALID & WREADY;
  assign b_hs       = BVALID & BREADY;
  assign last_beat  = (cnt == 4'd0);
  // WLAST must be high exactly on the AWLEN-counted final beat.
  assign beat_err   = WLAST ^ last_beat;
  assign beat_write = w_hs & (|WSTRB) & ~dec;

`ifdef DMA_WR_RESP_ADDR_CHECK_EN
  // End of the burst in bytes, one bit wider so the sum cannot overflow.
  logic [4:0]  len_beats;
  logic [32:0] burst_end;
  assign len_beats = {1'b0, AWLEN} + 5'd1;
  assign burst_end = {1'b0, AWADDR} + {26'd0, len_beats, 2'b00};
  assign aw_dec    = (burst_end > {1'b0, ADDR_LIMIT});
`else
  logic [31:0] unused_addr_limit;
  assign unused_addr_limit = ADDR_LIMIT;
  assign aw_dec = 1'b0;
`endif

  // Byte-offset and above-SRAM address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, AWADDR[1:0], AWADDR[31:MEM_AW+2]};

  // Burst control FSM: handshake flags, burst pointer/counter, B response.
  // NOTE: every register here is assigned with <= so all of them update
  // together from the same pre-edge values; blocking = would let later
  // statements see half-updated state.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= S_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= RESP_OKAY;
      ptr     <= '0;
      cnt     <= 4'd0;
      err     <= 1'b0;
      dec     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // AWREADY rises one cycle after entering IDLE and drops on accept.
          AWREADY <= ~aw_hs;
          if (aw_hs) begin
            BID    <= AWID;
            ptr    <= AWADDR[MEM_AW+1:2];
            cnt    <= AWLEN;
            err    <= 1'b0;
            dec    <= aw_dec;
            WREADY <= 1'b1;
            state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            ptr <= ptr + MEM_AW'(1);
            cnt <= cnt - 4'd1;
            if (last_beat) begin
              WREADY <= 1'b0;
              BVALID <= 1'b1;
              if (dec)
                BRESP <= RESP_DECERR;
              else if (err | beat_err)
                BRESP <= RESP_SLVERR;
              else
                BRESP <= RESP_OKAY;
              state <= S_RESP;
            end else begin
              err <= err | beat_err;
            end
          end
        end
        S_RESP: begin
          if (b_hs) begin
            BVALID <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          AWREADY <= 1'b0;
          WREADY  <= 1'b0;
          BVALID  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // SRAM port: one-cycle strobe per written beat; address/data hold between writes.
  // NOTE: only the port registers are reset here; the SRAM array itself lives
  // outside this block and is never cleared by reset.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      mem_cs    <= 1'b0;
      mem_we    <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      mem_cs <= beat_write;
      mem_we <= beat_write ? WSTRB : 4'd0;
      if (beat_write) begin
        mem_addr  <= ptr;
        mem_wdata <= WDATA;
      end
    end
  end

endmodule
